// File: rtl/axist_csr_avmm_responder_if.sv
// Avalon-MM bus bundle between the host master and the CSR responder.
interface axist_csr_avmm_responder_if;
    logic [31:0] address;
    logic        write;
    logic        read;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        readdatavalid;

    modport master (
        output address, write, read, writedata, byteenable,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, write, read, writedata, byteenable,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/axist_csr_avmm_responder.sv
// CSR responder for the AXI-ST dual-link test system: control/status registers plus snapshot-coherent capture windows.
// Optional decode-error reporting and counter enabled by defining AXIST_CSR_DECERR_EN.
module axist_csr_avmm_responder #(
    parameter int unsigned READ_LATENCY = 2,
    parameter logic [31:0] BASE_ADDR    = 32'h5000_0000,
    parameter int unsigned NUM_WIN      = 8
) (
    input  logic                     avmm_clk,
    input  logic                     i_rst,
    axist_csr_avmm_responder_if.slave avmm,
    input  logic [31:0]              i_l2f_ckr_sts,
    input  logic [31:0]              i_f2l_ckr_sts,
    input  logic [3:0]               i_linkup_sts,
    input  logic [NUM_WIN*256-1:0]   i_cap_data,
    output logic [31:0]              o_delay_x,
    output logic [31:0]              o_delay_y,
    output logic [31:0]              o_delay_z,
    output logic                     o_axi_rst,
    output logic [31:0]              o_tx_pkt_ctrl,
    output logic [31:0]              o_f2l_tx_pkt_ctrl,
    output logic                     o_tx_start,
    output logic                     o_f2l_tx_start,
    output logic                     o_decerr
);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic [31:0]   hold;
    logic          wait_q;
    logic          rdv_q;
    logic [31:0]   rdata_q;
    logic [31:0]   axi_ctrl;
    logic [255:0]  shadow;
    logic [2:0]    shadow_tag;
    logic          shadow_vld;

    logic [15:0]   offset;
    logic          base_hit;
    logic          win_hit;
    logic [2:0]    win_idx;
    logic [2:0]    word_idx;
    logic [255:0]  live_win;
    logic [31:0]   rd_val;
    logic          mapped;
    logic          accept_wr;
    logic          accept_rd;

`ifdef AXIST_CSR_DECERR_EN
    logic [15:0]   err_cnt;
    logic          decerr_q;
    assign o_decerr = decerr_q;
`else
    assign o_decerr = 1'b0;
`endif

    assign avmm.waitrequest   = wait_q;
    assign avmm.readdatavalid = rdv_q;
    assign avmm.readdata      = rdata_q;
    assign o_axi_rst          = axi_ctrl[0];

    assign offset    = avmm.address[15:0];
    assign base_hit  = (avmm.address[31:16] == BASE_ADDR[31:16]);
    assign win_idx   = {offset[12], offset[9:8]};
    assign word_idx  = offset[4:2];
    assign win_hit   = base_hit && (offset[15:13] == 3'b010) && (offset[11:10] == 2'b00)
                       && (offset[7:5] == 3'b000) && (offset[1:0] == 2'b00);
    assign live_win  = i_cap_data[{win_idx, 8'd0} +: 256];
    assign accept_wr = avmm.write && !wait_q;
    // A simultaneous write wins; the read is dropped entirely.
    assign accept_rd = avmm.read && !avmm.write && !wait_q;

    function automatic logic [31:0] be_merge(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int unsigned i = 0; i < 4; i++)
            if (be[i]) r[i*8 +: 8] = wd[i*8 +: 8];
        return r;
    endfunction

    always_comb begin
        rd_val = '0;
        mapped = 1'b0;
        if (base_hit) begin
            mapped = 1'b1;
            case (offset)
                16'h2000: rd_val = o_delay_x;
                16'h2004: rd_val = o_delay_y;
                16'h2008: rd_val = o_delay_z;
                16'h3000: rd_val = axi_ctrl;
                16'h1000: rd_val = o_tx_pkt_ctrl;
                16'h1004: rd_val = i_l2f_ckr_sts;
                16'h1008: rd_val = o_f2l_tx_pkt_ctrl;
                16'h100C: rd_val = i_f2l_ckr_sts;
                16'h1010: rd_val = {28'd0, i_linkup_sts};
`ifdef AXIST_CSR_DECERR_EN
                16'h1014: rd_val = {16'd0, err_cnt};
`endif
                default: begin
                    if (win_hit) begin
                        // Words 1..7 of the tagged window come from the word-0 snapshot.
                        if (word_idx != 3'd0 && shadow_vld && shadow_tag == win_idx)
                            rd_val = shadow[{word_idx, 5'd0} +: 32];
                        else
                            rd_val = live_win[{word_idx, 5'd0} +: 32];
                    end else begin
                        mapped = 1'b0;
                    end
                end
            endcase
        end
`ifdef AXIST_CSR_DECERR_EN
        if (!mapped) rd_val = 32'hBADADD00;
`endif
    end

    always_ff @(posedge avmm_clk) begin
        if (i_rst) begin
            state             <= S_IDLE;
            cnt               <= '0;
            hold              <= '0;
            wait_q            <= 1'b0;
            rdv_q             <= 1'b0;
            rdata_q           <= '0;
            axi_ctrl          <= '0;
            shadow            <= '0;
            shadow_tag        <= '0;
            shadow_vld        <= 1'b0;
            o_delay_x         <= '0;
            o_delay_y         <= '0;
            o_delay_z         <= '0;
            o_tx_pkt_ctrl     <= '0;
            o_f2l_tx_pkt_ctrl <= '0;
            o_tx_start        <= 1'b0;
            o_f2l_tx_start    <= 1'b0;
`ifdef AXIST_CSR_DECERR_EN
            err_cnt           <= '0;
            decerr_q          <= 1'b0;
`endif
        end else begin
            o_tx_start     <= 1'b0;
            o_f2l_tx_start <= 1'b0;
            rdv_q          <= 1'b0;

            if (accept_wr && base_hit) begin
                case (offset)
                    16'h2000: o_delay_x <= be_merge(o_delay_x, avmm.writedata, avmm.byteenable);
                    16'h2004: o_delay_y <= be_merge(o_delay_y, avmm.writedata, avmm.byteenable);
                    16'h2008: o_delay_z <= be_merge(o_delay_z, avmm.writedata, avmm.byteenable);
                    16'h3000: axi_ctrl  <= be_merge(axi_ctrl, avmm.writedata, avmm.byteenable);
                    16'h1000: begin
                        o_tx_pkt_ctrl <= be_merge(o_tx_pkt_ctrl, avmm.writedata, avmm.byteenable);
                        o_tx_start    <= avmm.byteenable[0] && avmm.writedata[0];
                    end
                    16'h1008: begin
                        o_f2l_tx_pkt_ctrl <= be_merge(o_f2l_tx_pkt_ctrl, avmm.writedata, avmm.byteenable);
                        o_f2l_tx_start    <= avmm.byteenable[0] && avmm.writedata[0];
                    end
                    default: ;
                endcase
            end

`ifdef AXIST_CSR_DECERR_EN
            decerr_q <= 1'b0;
            if ((accept_wr || accept_rd) && !mapped) begin
                decerr_q <= 1'b1;
                if (err_cnt != '1) err_cnt <= err_cnt + 16'd1;
            end
`endif

            case (state)
                S_IDLE: begin
                    if (accept_rd) begin
                        if (win_hit && word_idx == 3'd0) begin
                            shadow     <= live_win;
                            shadow_tag <= win_idx;
                            shadow_vld <= 1'b1;
                        end
                        // Latency 1 bypasses the hold stage; longer latencies release it at cnt==2.
                        if (READ_LATENCY == 1) begin
                            rdata_q <= rd_val;
                            rdv_q   <= 1'b1;
                        end else begin
                            hold <= rd_val;
                        end
                        cnt    <= 4'(READ_LATENCY);
                        wait_q <= 1'b1;
                        state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd2) begin
                        rdata_q <= hold;
                        rdv_q   <= 1'b1;
                    end
                    if (cnt == 4'd1) begin
                        wait_q <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axist_csr_avmm_responder.sv
// Scoreboard bench for axist_csr_avmm_responder; follows AXIST_CSR_DECERR_EN like the design.
module tb_axist_csr_avmm_responder;

    localparam int RL = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [31:0]    l2f_sts, f2l_sts;
    logic [3:0]     linkup;
    logic [2047:0]  cap, old_cap;
    logic [31:0]    delay_x, delay_y, delay_z, tx_ctrl, f2l_ctrl;
    logic           axi_rst, tx_start, f2l_start, decerr;

    int             pass_cnt = 0;
    int             total_cnt = 0;
    int             cyc = 0;
    int             dec_pulses = 0;
    logic [31:0]    exp_q[$];
    int             acc_q[$];

    axist_csr_avmm_responder_if bus ();

    axist_csr_avmm_responder #(.READ_LATENCY(RL), .BASE_ADDR(32'h5000_0000), .NUM_WIN(8)) dut (
        .avmm_clk          (clk),
        .i_rst             (rst),
        .avmm              (bus.slave),
        .i_l2f_ckr_sts     (l2f_sts),
        .i_f2l_ckr_sts     (f2l_sts),
        .i_linkup_sts      (linkup),
        .i_cap_data        (cap),
        .o_delay_x         (delay_x),
        .o_delay_y         (delay_y),
        .o_delay_z         (delay_z),
        .o_axi_rst         (axi_rst),
        .o_tx_pkt_ctrl     (tx_ctrl),
        .o_f2l_tx_pkt_ctrl (f2l_ctrl),
        .o_tx_start        (tx_start),
        .o_f2l_tx_start    (f2l_start),
        .o_decerr          (decerr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Read-response scoreboard: every readdatavalid must match the oldest pushed expectation.
    always @(negedge clk) begin
        if (decerr === 1'b1) dec_pulses++;
        if (bus.readdatavalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_rdv: got readdatavalid with data %h, required none", bus.readdata);
            end else begin
                logic [31:0] e;
                int          a;
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                total_cnt++;
                if (bus.readdata !== e)
                    $display("FAIL read_data: got %h, required %h", bus.readdata, e);
                else pass_cnt++;
                total_cnt++;
                if (cyc - a != RL)
                    $display("FAIL read_latency: got %0d, required %0d", cyc - a, RL);
                else pass_cnt++;
            end
        end
    end

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        total_cnt++;
        if (exp_q.size() != 0) begin
            $display("FAIL drain_timeout: got %0d pending reads, required 0", exp_q.size());
            exp_q.delete();
            acc_q.delete();
        end else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        int n = 0;
        bus.address = a; bus.writedata = d; bus.byteenable = be; bus.write = 1'b1;
        @(negedge clk);
        while (bus.waitrequest !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total_cnt++;
            $display("FAIL write_wait_timeout: got waitrequest %b, required 0", bus.waitrequest);
        end
        @(posedge clk); #1;
        bus.write = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e);
        int n = 0;
        bus.address = a; bus.read = 1'b1;
        @(negedge clk);
        while (bus.waitrequest !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total_cnt++;
            $display("FAIL read_wait_timeout: got waitrequest %b, required 0", bus.waitrequest);
        end else begin
            exp_q.push_back(e);
            acc_q.push_back(cyc);
        end
        @(posedge clk); #1;
        bus.read = 1'b0;
        drain();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({bus.waitrequest, bus.readdatavalid, bus.readdata} !== 34'd0)
            $display("FAIL reset_bus: got wr=%b rdv=%b data=%h, required 0", bus.waitrequest, bus.readdatavalid, bus.readdata);
        else pass_cnt++;
        total_cnt++;
        if ({delay_x, delay_y, delay_z, tx_ctrl, f2l_ctrl} !== 160'd0)
            $display("FAIL reset_regs: got %h %h %h %h %h, required 0", delay_x, delay_y, delay_z, tx_ctrl, f2l_ctrl);
        else pass_cnt++;
        total_cnt++;
        if ({axi_rst, tx_start, f2l_start, decerr} !== 4'd0)
            $display("FAIL reset_pulses: got %b, required 0000", {axi_rst, tx_start, f2l_start, decerr});
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_delay_rw();
        wr(32'h5000_2008, 32'h0000_1770, 4'hF);
        @(negedge clk);
        total_cnt++;
        if (delay_z !== 32'h0000_1770) $display("FAIL delay_z: got %h, required 00001770", delay_z);
        else pass_cnt++;
        @(posedge clk); #1;
        rd(32'h5000_2008, 32'h0000_1770);
        wr(32'h5000_2000, 32'hAABB_CCDD, 4'b0101);
        @(negedge clk);
        total_cnt++;
        if (delay_x !== 32'h00BB_00DD) $display("FAIL delay_x_bytelane: got %h, required 00bb00dd", delay_x);
        else pass_cnt++;
        @(posedge clk); #1;
        rd(32'h5000_2000, 32'h00BB_00DD);
        wr(32'h5000_3000, 32'h0000_0001, 4'h1);
        @(negedge clk);
        total_cnt++;
        if (axi_rst !== 1'b1) $display("FAIL axi_rst: got %b, required 1", axi_rst);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_tx_start();
        int pulses;
        logic first;
        wr(32'h5000_1000, 32'h0000_0FF5, 4'hF);
        pulses = 0;
        first = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) first = tx_start;
            if (tx_start === 1'b1) pulses++;
        end
        total_cnt++;
        if (!first || pulses != 1) $display("FAIL tx_start_pulse: got first=%b pulses=%0d, required 1/1", first, pulses);
        else pass_cnt++;
        total_cnt++;
        if (tx_ctrl !== 32'h0000_0FF5) $display("FAIL tx_ctrl: got %h, required 00000ff5", tx_ctrl);
        else pass_cnt++;
        @(posedge clk); #1;
        wr(32'h5000_1000, 32'h0000_0FF4, 4'hF);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (tx_start === 1'b1) pulses++;
        end
        total_cnt++;
        if (pulses != 0) $display("FAIL tx_start_nopulse: got %0d pulses, required 0", pulses);
        else pass_cnt++;
        @(posedge clk); #1;
        wr(32'h5000_1008, 32'h0000_0003, 4'h1);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (f2l_start === 1'b1) pulses++;
        end
        total_cnt++;
        if (pulses != 1 || f2l_ctrl !== 32'h3) $display("FAIL f2l_start: got pulses=%0d ctrl=%h, required 1 and 00000003", pulses, f2l_ctrl);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_held_read();
        int accepts = 0;
        int waits = 0;
        linkup = 4'hF;
        bus.address = 32'h5000_1010;
        bus.read = 1'b1;
        for (int i = 0; i < RL + 2; i++) begin
            @(negedge clk);
            if (bus.waitrequest === 1'b0) begin
                accepts++;
                exp_q.push_back(32'h0000_000F);
                acc_q.push_back(cyc);
            end else waits++;
            @(posedge clk); #1;
        end
        bus.read = 1'b0;
        drain();
        total_cnt++;
        if (accepts != 2 || waits != RL) $display("FAIL held_read: got accepts=%0d waits=%0d, required 2 and %0d", accepts, waits, RL);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (bus.readdata !== 32'h0000_000F) $display("FAIL readdata_hold: got %h, required 0000000f", bus.readdata);
        else pass_cnt++;
        @(posedge clk); #1;
        rd(32'h5000_1004, l2f_sts);
        rd(32'h5000_100C, f2l_sts);
    endtask

    task automatic test_snapshot();
        for (int i = 0; i < 64; i++) cap[i*32 +: 32] = $urandom;
        old_cap = cap;
        rd(32'h5000_4000, old_cap[31:0]);
        for (int i = 0; i < 64; i++) cap[i*32 +: 32] = $urandom;
        for (int k = 1; k < 8; k++)
            rd(32'h5000_4000 + 32'(k * 4), old_cap[k*32 +: 32]);
        rd(32'h5000_510C, cap[5*256 + 96 +: 32]);
        old_cap = cap;
        rd(32'h5000_5100, old_cap[5*256 +: 32]);
        for (int i = 0; i < 64; i++) cap[i*32 +: 32] = $urandom;
        rd(32'h5000_5114, old_cap[5*256 + 160 +: 32]);
        rd(32'h5000_4304, cap[3*256 + 32 +: 32]);
    endtask

    task automatic test_collision();
        int rdvs = 0;
        bus.address = 32'h5000_2004; bus.writedata = 32'h1234_5678; bus.byteenable = 4'hF;
        bus.write = 1'b1; bus.read = 1'b1;
        @(posedge clk); #1;
        bus.write = 1'b0; bus.read = 1'b0;
        for (int i = 0; i < RL + 3; i++) begin
            @(negedge clk);
            if (bus.readdatavalid === 1'b1) rdvs++;
        end
        total_cnt++;
        if (delay_y !== 32'h1234_5678 || rdvs != 0) $display("FAIL collision: got delay_y=%h rdv=%0d, required 12345678 and 0", delay_y, rdvs);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_inflight();
        int rdvs = 0;
        bus.address = 32'h5000_2008; bus.read = 1'b1;
        @(posedge clk); #1;
        bus.read = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < RL + 3; i++) begin
            @(negedge clk);
            if (bus.readdatavalid === 1'b1) rdvs++;
        end
        total_cnt++;
        if (rdvs != 0) $display("FAIL inflight_rdv: got %0d, required 0", rdvs);
        else pass_cnt++;
        total_cnt++;
        if ({bus.waitrequest, bus.readdata, delay_z, delay_y, tx_ctrl, axi_rst} !== 130'd0)
            $display("FAIL inflight_outputs: got wr=%b data=%h z=%h y=%h tx=%h axi=%b, required 0",
                     bus.waitrequest, bus.readdata, delay_z, delay_y, tx_ctrl, axi_rst);
        else pass_cnt++;
        @(posedge clk); #1;
        rd(32'h5000_2008, 32'h0);
    endtask

    task automatic test_unmapped();
        dec_pulses = 0;
`ifdef AXIST_CSR_DECERR_EN
        rd(32'h5000_7000, 32'hBADADD00);
        rd(32'h5000_1014, 32'h0000_0001);
        total_cnt++;
        if (dec_pulses != 1) $display("FAIL decerr_pulse: got %0d, required 1", dec_pulses);
        else pass_cnt++;
        rd(32'h6000_2000, 32'hBADADD00);
`else
        rd(32'h5000_7000, 32'h0);
        rd(32'h5000_1014, 32'h0);
        wr(32'h5000_7000, 32'hFFFF_FFFF, 4'hF);
        rd(32'h6000_2000, 32'h0);
        total_cnt++;
        if (dec_pulses != 0) $display("FAIL decerr_pulse: got %0d, required 0", dec_pulses);
        else pass_cnt++;
`endif
    endtask

    initial begin
        rst = 1'b1;
        bus.address = '0; bus.write = 1'b0; bus.read = 1'b0;
        bus.writedata = '0; bus.byteenable = '0;
        l2f_sts = 32'hC0DE_0001; f2l_sts = 32'hC0DE_0002; linkup = 4'h0;
        cap = '0; old_cap = '0;
        @(posedge clk); #1;
        test_reset();
        test_delay_rw();
        test_tx_start();
        test_held_read();
        test_snapshot();
        test_collision();
        test_reset_inflight();
        test_unmapped();
        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
